// File: rtl/puf_response_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : puf_pkg                                                        |
// | Shared constants for the race-PUF response sequencer: FSM state          |
// | encoding, Galois LFSR tap masks per supported challenge width and the    |
// | default timing parameters.                                               |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package puf_pkg;

    // Default build parameters
    localparam int unsigned c_def_chal_w        = 64;
    localparam int unsigned c_def_resp_bits     = 32;
    localparam int unsigned c_def_race_cycles   = 16;
    localparam int unsigned c_def_settle_cycles = 4;

    // Sequencer state encoding
    localparam int unsigned             c_state_w   = 3;
    localparam logic [c_state_w-1:0]    c_st_idle    = 3'd0;
    localparam logic [c_state_w-1:0]    c_st_load    = 3'd1;
    localparam logic [c_state_w-1:0]    c_st_race    = 3'd2;
    localparam logic [c_state_w-1:0]    c_st_settle  = 3'd3;
    localparam logic [c_state_w-1:0]    c_st_capture = 3'd4;
    localparam logic [c_state_w-1:0]    c_st_done    = 3'd5;

    // Galois tap masks (bit k set => XOR into bit k when the MSB shifts out)
    // 32 : x^32 + x^22 + x^2 + x + 1
    // 64 : x^64 + x^63 + x^61 + x^60 + 1
    // 128: x^128 + x^126 + x^101 + x^99 + 1
    localparam logic [31:0]  c_lfsr_taps_32  = 32'h0040_0007;
    localparam logic [63:0]  c_lfsr_taps_64  = 64'hB000_0000_0000_0001;
    localparam logic [127:0] c_lfsr_taps_128 = 128'h4000_0028_0000_0000_0000_0000_0000_0001;

    // Tap mask for a given width, right-aligned in 128 bits; unsupported
    // widths fall back to a plain feedback into bit 0.
    function automatic logic [127:0] lfsr_taps(input int unsigned width);
        logic [127:0] taps;
        case (width)
            32:      taps = {96'd0, c_lfsr_taps_32};
            64:      taps = {64'd0, c_lfsr_taps_64};
            128:     taps = c_lfsr_taps_128;
            default: taps = 128'd1;
        endcase
        return taps;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_response_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : puf_response_sequencer_if                                    |
// | Bundles the host request/response handshake and the PUF datapath         |
// | signals of the response sequencer.                                       |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface puf_response_sequencer_if
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W    = c_def_chal_w,
    parameter int unsigned RESP_BITS = c_def_resp_bits
);
    logic                 start;
    logic [CHAL_W-1:0]    seed;
    logic [CHAL_W-1:0]    challenge;
    logic                 race_enable;
    logic                 arb_out;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;

    // Requester side: host command layer plus the arbiter result
    modport master (
        output start, seed, arb_out,
        input  challenge, race_enable, busy, done, response
    );

    // Sequencer side
    modport slave (
        input  start, seed, arb_out,
        output challenge, race_enable, busy, done, response
    );
endinterface
`default_nettype wire

// File: rtl/puf_response_sequencer_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : challenge_lfsr                                                  |
// | Registered challenge generator: load a seed, step a left-shifting        |
// | Galois LFSR, or hold. A zero state is legal and stays zero.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module challenge_lfsr
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W = c_def_chal_w
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              i_load,
    input  wire              i_step,
    input  wire [CHAL_W-1:0] i_seed,
    output logic [CHAL_W-1:0] o_challenge
);

    localparam logic [CHAL_W-1:0] c_taps = CHAL_W'(lfsr_taps(CHAL_W));

    logic [CHAL_W-1:0] r_chal;
    logic [CHAL_W-1:0] w_next;

    // Next LFSR state: shift left, fold taps in when the MSB falls out
    always_comb begin
        w_next = {r_chal[CHAL_W-2:0], 1'b0};
        if (r_chal[CHAL_W-1]) begin
            w_next = w_next ^ c_taps;
        end
    end

    // Challenge register; load has priority over step, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chal <= '0;
        end else if (i_load) begin
            r_chal <= i_seed;
        end else if (i_step) begin
            r_chal <= w_next;
        end
    end

    assign o_challenge = r_chal;

endmodule
`default_nettype wire

// File: rtl/puf_response_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : puf_response_sequencer                                          |
// | Drives the delay-based race PUF one bit at a time: load challenge,       |
// | race, settle, capture arbiter result, advance LFSR; repeats RESP_BITS    |
// | times from a single seed and reports the response with a done pulse.     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int unsigned CHAL_W        = c_def_chal_w,
    parameter int unsigned RESP_BITS     = c_def_resp_bits,
    parameter int unsigned RACE_CYCLES   = c_def_race_cycles,
    parameter int unsigned SETTLE_CYCLES = c_def_settle_cycles
) (
    input  wire                     clk,
    input  wire                     reset_n,
    puf_response_sequencer_if.slave bus
);

    // One counter serves both the race and the settle phase
    localparam int unsigned c_cnt_max = max_u(RACE_CYCLES, SETTLE_CYCLES);
    localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int unsigned c_idx_w   = $clog2(RESP_BITS) + 1;

    localparam logic [c_cnt_w-1:0] c_race_last   = c_cnt_w'(RACE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_bit_last    = c_idx_w'(RESP_BITS - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [c_idx_w-1:0]   w_bit_idx_nxt;
    logic [RESP_BITS-1:0] r_response;
    logic [RESP_BITS-1:0] w_response_nxt;
    logic                 r_race_en;
    logic                 w_race_en_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_lfsr_load;
    logic                 w_lfsr_step;
    logic [CHAL_W-1:0]    w_challenge;

    // Challenge source; only moves on accepted start (load) or capture (step)
    challenge_lfsr #(
        .CHAL_W (CHAL_W)
    ) u_challenge_lfsr (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_lfsr_load),
        .i_step      (w_lfsr_step),
        .i_seed      (bus.seed),
        .o_challenge (w_challenge)
    );

    // State and registered outputs; async reset drops race_enable at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_response <= '0;
            r_race_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_response <= w_response_nxt;
            r_race_en  <= w_race_en_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output decode for the per-bit sequence
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_response_nxt = r_response;
        w_race_en_nxt  = r_race_en;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_lfsr_load    = 1'b0;
        w_lfsr_step    = 1'b0;

        case (r_state)
            c_st_idle: begin
                // Only IDLE looks at start; no queuing elsewhere
                if (bus.start) begin
                    w_state_nxt    = c_st_load;
                    w_lfsr_load    = 1'b1;
                    w_bit_idx_nxt  = '0;
                    w_response_nxt = '0;
                    w_busy_nxt     = 1'b1;
                end
            end

            c_st_load: begin
                // Challenge has been stable for a full cycle before launch
                w_state_nxt   = c_st_race;
                w_race_en_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end

            c_st_race: begin
                if (r_cnt == c_race_last) begin
                    w_state_nxt   = c_st_settle;
                    w_race_en_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_st_settle: begin
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = c_st_capture;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_st_capture: begin
                for (int i = 0; i < int'(RESP_BITS); i++) begin
                    if (r_bit_idx == c_idx_w'(i)) begin
                        w_response_nxt[i] = bus.arb_out;
                    end
                end
                w_lfsr_step = 1'b1;
                if (r_bit_idx == c_bit_last) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    w_state_nxt   = c_st_load;
                end
            end

            c_st_done: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_st_idle;
            end

            default: begin
                w_state_nxt   = c_st_idle;
                w_race_en_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    assign bus.challenge   = w_challenge;
    assign bus.race_enable = r_race_en;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.response    = r_response;

endmodule
`default_nettype wire

// File: tb/tb_puf_response_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_puf_response_sequencer                                       |
// | Bench for the race-PUF response sequencer: a default-size instance and   |
// | a minimal (1 bit, 1/1 cycle) instance, with an arbiter model and a       |
// | behavioural LFSR reference.                                              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_puf_response_sequencer;
    import puf_pkg::*;

    localparam int c_resp_bits = 32;
    localparam int c_race      = 16;
    localparam int c_settle    = 4;
    localparam int c_latency   = 1 + c_resp_bits * (1 + c_race + c_settle + 1) + 1;
    localparam int c_latency_b = 1 + 1 * (1 + 1 + 1 + 1) + 1;
    localparam int c_budget    = 1000;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    int          tests_run    = 0;
    int          tests_failed = 0;

    logic        start_a = 1'b0;
    logic [63:0] seed_a  = '0;
    logic        arb_a   = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] seed_b  = '0;
    logic        arb_b   = 1'b0;

    puf_response_sequencer_if #(.CHAL_W(64), .RESP_BITS(32)) bus_a ();
    puf_response_sequencer_if #(.CHAL_W(32), .RESP_BITS(1))  bus_b ();

    assign bus_a.start   = start_a;
    assign bus_a.seed    = seed_a;
    assign bus_a.arb_out = arb_a;
    assign bus_b.start   = start_b;
    assign bus_b.seed    = seed_b;
    assign bus_b.arb_out = arb_b;

    puf_response_sequencer #(
        .CHAL_W(64), .RESP_BITS(32), .RACE_CYCLES(16), .SETTLE_CYCLES(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    puf_response_sequencer #(
        .CHAL_W(32), .RESP_BITS(1), .RACE_CYCLES(1), .SETTLE_CYCLES(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference: response bit i is bit 0 of the i-th LFSR state from the seed
    function automatic logic [31:0] model_track(input logic [63:0] s);
        logic [63:0] c = s;
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = c[0];
            c = c[63] ? ((c << 1) ^ c_lfsr_taps_64) : (c << 1);
        end
        return r;
    endfunction

    task automatic launch_a(input logic [63:0] s);
        @(negedge clk);
        seed_a  = s;
        start_a = 1'b1;
    endtask

    // Follows one run of dut_a from the cycle after acceptance until done.
    // mode: 0 arbiter always 1, 1 arbiter = challenge[0] at race fall, 2 random.
    task automatic wait_done_a(input logic [63:0] run_seed, input int spur1, input int spur2,
                               input bit hold, input logic [63:0] hold_seed, input int mode,
                               output int lat, output logic [31:0] gen_bits);
        int          n = 0;
        bit          prev_re = 1'b0;
        bit          seen_pulse = 1'b0;
        bit          chal_moved = 1'b0;
        int          hi = 0;
        int          lo = 0;
        int          bit_no = 0;
        logic [63:0] chal_hold = '0;
        lat = -1;
        gen_bits = '0;
        while (lat < 0 && n < c_budget) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                tests_run++;
                if (bus_a.busy !== 1'b1 || bus_a.response !== 32'd0 || bus_a.challenge !== run_seed) begin
                    tests_failed++;
                    $display("FAIL run_start: busy=%b resp=%h chal=%h expected busy=1 resp=0 chal=%h",
                             bus_a.busy, bus_a.response, bus_a.challenge, run_seed);
                end
            end
            if (hold) begin
                start_a = 1'b1;
                if (n == 1) seed_a = hold_seed;
            end else if (n == spur1 || n == spur2) begin
                start_a = 1'b1;
                seed_a  = {$urandom, $urandom};
            end else begin
                start_a = 1'b0;
            end
            if (bus_a.race_enable) begin
                if (!prev_re) begin
                    if (seen_pulse) begin
                        tests_run++;
                        if (lo !== c_settle + 2) begin
                            tests_failed++;
                            $display("FAIL race_gap: low for %0d cycles expected %0d", lo, c_settle + 2);
                        end
                    end
                    chal_hold  = bus_a.challenge;
                    chal_moved = 1'b0;
                    hi = 1;
                end else begin
                    hi++;
                    if (bus_a.challenge !== chal_hold) chal_moved = 1'b1;
                end
            end else begin
                if (prev_re) begin
                    tests_run++;
                    if (hi !== c_race || chal_moved !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL race_pulse: high %0d cycles chal_moved=%b expected %0d and 0",
                                 hi, chal_moved, c_race);
                    end
                    seen_pulse = 1'b1;
                    lo = 1;
                    case (mode)
                        0:       arb_a = 1'b1;
                        1:       arb_a = bus_a.challenge[0];
                        default: arb_a = 1'($urandom_range(0, 1));
                    endcase
                    if (bit_no < 32) gen_bits[bit_no] = arb_a;
                    bit_no++;
                end else begin
                    lo++;
                end
            end
            prev_re = bus_a.race_enable;
            if (bus_a.done === 1'b1) lat = n;
        end
        tests_run++;
        if (lat != c_latency) begin
            tests_failed++;
            $display("FAIL latency: done at cycle %0d expected %0d", lat, c_latency);
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_a.challenge !== 64'd0 || bus_a.race_enable !== 1'b0 || bus_a.busy !== 1'b0 ||
            bus_a.done !== 1'b0 || bus_a.response !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_a: chal=%h re=%b busy=%b done=%b resp=%h expected all 0",
                     bus_a.challenge, bus_a.race_enable, bus_a.busy, bus_a.done, bus_a.response);
        end
        tests_run++;
        if (bus_b.challenge !== 32'd0 || bus_b.busy !== 1'b0 || bus_b.done !== 1'b0 ||
            bus_b.response !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_b: chal=%h busy=%b done=%b resp=%b expected all 0",
                     bus_b.challenge, bus_b.busy, bus_b.done, bus_b.response);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mid_run_reset();
        int  rises = 0;
        int  n = 0;
        bit  prev = 1'b0;
        bit  saw_done = 1'b0;
        arb_a = 1'b1;
        launch_a({$urandom, $urandom});
        @(negedge clk);
        start_a = 1'b0;
        while (rises < 4 && n < c_budget) begin
            @(negedge clk);
            n++;
            if (bus_a.race_enable && !prev) rises++;
            prev = bus_a.race_enable;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_a.response !== 32'h0000_0007 || bus_a.race_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: resp=%h re=%b expected 00000007 and 1", bus_a.response, bus_a.race_enable);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus_a.race_enable !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.response !== 32'd0 ||
            bus_a.challenge !== 64'd0) begin
            tests_failed++;
            $display("FAIL async_reset: re=%b busy=%b resp=%h chal=%h expected all 0",
                     bus_a.race_enable, bus_a.busy, bus_a.response, bus_a.challenge);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (800) begin
            @(negedge clk);
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_done: activity seen after abort=%b expected 0", saw_done);
        end
    endtask

    task automatic test_const_one();
        int          lat;
        logic [31:0] bits;
        launch_a(64'h1);
        wait_done_a(64'h1, -1, -1, 1'b0, 64'd0, 0, lat, bits);
        tests_run++;
        if (bus_a.response !== 32'hFFFF_FFFF || bus_a.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL const_one: resp=%h busy=%b expected ffffffff and 0", bus_a.response, bus_a.busy);
        end
        @(negedge clk);
        tests_run++;
        if (bus_a.done !== 1'b0 || bus_a.response !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL done_pulse: done=%b resp=%h expected 0 and ffffffff", bus_a.done, bus_a.response);
        end
    endtask

    task automatic test_lfsr_track();
        logic [63:0] seeds [4];
        int          lat;
        logic [31:0] bits;
        seeds[0] = 64'hDEAD_BEEF_0123_4567;
        seeds[1] = 64'd0;
        seeds[2] = {$urandom, $urandom};
        seeds[3] = {1'b1, 31'($urandom), $urandom};
        for (int k = 0; k < 4; k++) begin
            launch_a(seeds[k]);
            wait_done_a(seeds[k], -1, -1, 1'b0, 64'd0, 1, lat, bits);
            tests_run++;
            if (bus_a.response !== model_track(seeds[k])) begin
                tests_failed++;
                $display("FAIL lfsr_track: seed=%h resp=%h expected %h",
                         seeds[k], bus_a.response, model_track(seeds[k]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_arb();
        int          lat;
        logic [31:0] bits;
        logic [63:0] s;
        for (int k = 0; k < 3; k++) begin
            s = {$urandom, $urandom};
            launch_a(s);
            wait_done_a(s, -1, -1, 1'b0, 64'd0, 2, lat, bits);
            tests_run++;
            if (bus_a.response !== bits) begin
                tests_failed++;
                $display("FAIL random_arb: resp=%h expected %h", bus_a.response, bits);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] bits;
        logic [63:0] s1 = {$urandom, $urandom};
        logic [63:0] s2 = {$urandom, $urandom};
        logic [63:0] s3 = {$urandom, $urandom};
        // Spurious starts while busy and in the DONE cycle must not disturb the run
        launch_a(s1);
        wait_done_a(s1, 100, c_latency - 1, 1'b0, 64'd0, 1, lat, bits);
        tests_run++;
        if (bus_a.response !== model_track(s1)) begin
            tests_failed++;
            $display("FAIL start_ignored: resp=%h expected %h", bus_a.response, model_track(s1));
        end
        @(negedge clk);
        tests_run++;
        if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_queue: busy=%b done=%b expected 0 and 0", bus_a.busy, bus_a.done);
        end
        // Held-high start: the second run begins the cycle after done
        launch_a(s2);
        wait_done_a(s2, -1, -1, 1'b1, s3, 1, lat, bits);
        tests_run++;
        if (bus_a.response !== model_track(s2)) begin
            tests_failed++;
            $display("FAIL held_first: resp=%h expected %h", bus_a.response, model_track(s2));
        end
        wait_done_a(s3, -1, -1, 1'b0, 64'd0, 1, lat, bits);
        tests_run++;
        if (bus_a.response !== model_track(s3)) begin
            tests_failed++;
            $display("FAIL held_second: resp=%h expected %h", bus_a.response, model_track(s3));
        end
        @(negedge clk);
    endtask

    task automatic test_min_config();
        int n;
        for (int k = 0; k < 4; k++) begin
            arb_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            seed_b  = $urandom;
            start_b = 1'b1;
            n = 0;
            while (n < 50) begin
                @(negedge clk);
                n++;
                start_b = 1'b0;
                if (bus_b.done === 1'b1) break;
            end
            tests_run++;
            if (n != c_latency_b || bus_b.response !== arb_b) begin
                tests_failed++;
                $display("FAIL min_config: done at %0d resp=%b expected %0d and %b",
                         n, bus_b.response, c_latency_b, arb_b);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_mid_run_reset();
        test_const_one();
        test_lfsr_track();
        test_random_arb();
        test_back_to_back();
        test_min_config();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
